// File: rtl/cafe_order_scheduler.sv
// cafe_order_scheduler: shares one coffee machine between N_REQ order sources.
// Latches requests as pending orders, grants one, pulses mach_start, follows the
// machine state code until it returns to IDLE_CODE, then pulses done to the winner.
// A watchdog aborts a brew that does not complete within TIMEOUT cycles.
// Optional build macro: SCHED_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin arbitration.
module cafe_order_scheduler #(
  parameter int unsigned N_REQ     = 4,
  parameter logic [3:0]  IDLE_CODE = 4'd1,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             clr_err,
  input  logic [3:0]       mach_state,
  output logic             mach_start,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] pending,
  output logic             busy,
  output logic             timeout_err,
  output logic [2:0]       err_id
);

  localparam int unsigned   IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned   WW      = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_LEAVE,
    ST_WAIT_DONE,
    ST_DONE,
    ST_ABORT
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] pick;
  logic [N_REQ-1:0] clr_mask;
  logic [WW-1:0]    wd_q, wd_d;
  logic             timeout_err_q, timeout_err_d;
  logic [2:0]       err_id_q, err_id_d;
  logic [IW-1:0]    gidx;
  logic             found;

  // Binary index of the currently granted source.
  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) gidx = IW'(i);
    end
  end

`ifdef SCHED_FIXED_PRIO_EN
  // Fixed priority: lowest pending index wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && pending_q[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;

  // Round-robin: first pending source after the last one served, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IW'((32'(ptr_q) + k) % N_REQ);
      if (!found && pending_q[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // Pointer moves to the served source once its order finishes or aborts.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_DONE || state_q == ST_ABORT) ptr_d = gidx;
  end

  // Round-robin pointer register; reset value makes source 0 win first.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IW'(N_REQ - 1);
    else     ptr_q <= ptr_d;
  end
`endif

  // Next-state logic for the brew sequencer, watchdog, error flag and pending set.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    wd_d          = wd_q;
    timeout_err_d = clr_err ? 1'b0 : timeout_err_q;
    err_id_d      = clr_err ? 3'd0 : err_id_q;
    clr_mask      = '0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          state_d = ST_START;
          grant_d = pick;
        end
      end
      ST_START: begin
        wd_d    = '0;
        state_d = ST_WAIT_LEAVE;
      end
      ST_WAIT_LEAVE, ST_WAIT_DONE: begin
        wd_d = wd_q + 1'b1;
        // Watchdog expiry takes precedence over machine progress on the same cycle.
        if (wd_q == WD_LAST) begin
          state_d       = ST_ABORT;
          timeout_err_d = 1'b1;
          err_id_d      = 3'(gidx);
        end else if (state_q == ST_WAIT_LEAVE && mach_state != IDLE_CODE) begin
          state_d = ST_WAIT_DONE;
        end else if (state_q == ST_WAIT_DONE && mach_state == IDLE_CODE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_ABORT: begin
        clr_mask = grant_q;
        grant_d  = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A new request on the clearing edge re-queues the order.
    pending_d = (pending_q & ~clr_mask) | req;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      pending_q     <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
      err_id_q      <= 3'd0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      pending_q     <= pending_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
      err_id_q      <= err_id_d;
    end
  end

  assign mach_start  = (state_q == ST_START);
  assign grant       = grant_q;
  assign done        = (state_q == ST_DONE) ? grant_q : '0;
  assign pending     = pending_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = timeout_err_q;
  assign err_id      = err_id_q;

endmodule

// File: tb/tb_cafe_order_scheduler.sv
// Bench for cafe_order_scheduler: directed vector table, hand-written corner
// sequences and randomized traffic against a timeline-level reference model.
module tb_cafe_order_scheduler;

  localparam int         N  = 4;
  localparam logic [3:0] IC = 4'd1;
  localparam int         TO = 64;

  logic         clk = 1'b0;
  logic         rst, clr_err;
  logic [N-1:0] req;
  logic [3:0]   mach_state;
  logic         mach_start, busy, timeout_err;
  logic [N-1:0] grant, done, pending;
  logic [2:0]   err_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cafe_order_scheduler #(.N_REQ(N), .IDLE_CODE(IC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .clr_err(clr_err), .mach_state(mach_state),
    .mach_start(mach_start), .grant(grant), .done(done), .pending(pending),
    .busy(busy), .timeout_err(timeout_err), .err_id(err_id)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: order timeline ----------------
  logic [N-1:0] m_pend;
  int  m_ptr, m_cur, m_s, m_e, m_l, m_r, m_eid, cyc;
  bit  m_act, m_ab, m_stuck, m_err;
  // machine profile knobs
  bit  f_rand, f_stuck;
  int  f_a, f_b;

  function automatic int pick(input logic [N-1:0] p, input int ptr);
`ifdef SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (p[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return 0;
  endfunction

  function automatic logic [3:0] mach_val();
    if (m_act && !m_stuck && cyc >= m_l && cyc < m_r) return 4'(2 + (cyc - m_l) % 10);
    return IC;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_ptr = N - 1; m_act = 0; m_err = 0; m_eid = 0; m_ab = 0;
  endtask

  // Plan a new order: start next cycle, machine leaves after a, brews b cycles.
  task automatic model_plan();
    int a, b;
    bit st;
    if (f_rand) begin
      a  = $urandom_range(1, 3);
      b  = ($urandom_range(0, 15) == 0) ? $urandom_range(55, 66) : $urandom_range(1, 12);
      st = ($urandom_range(0, 31) == 0);
    end else begin
      a = f_a; b = f_b; st = f_stuck;
    end
    m_cur = pick(m_pend, m_ptr);
    m_s = cyc + 1; m_l = m_s + a; m_r = m_l + b; m_stuck = st;
    if (!st && m_r <= m_s + TO - 1) begin m_e = m_r + 1; m_ab = 0; end
    else begin m_e = m_s + TO + 1; m_ab = 1; end
    m_act = 1;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input bit clr, input bit rs);
    if (rs) begin model_reset(); return; end
    if (m_act && m_ab && cyc == m_e - 1) begin m_err = 1; m_eid = m_cur; end
    else if (clr) begin m_err = 0; m_eid = 0; end
    if (m_act && cyc == m_e) begin
      m_pend[m_cur] = 1'b0; m_ptr = m_cur; m_act = 0;
    end else if (!m_act && m_pend != '0) begin
      model_plan();
    end
    m_pend |= r;
  endtask

  task automatic cycle(input logic [N-1:0] r, input bit clr, input bit rs);
    logic [N-1:0] eg, ed;
    @(negedge clk);
    req = r; clr_err = clr; rst = rs; mach_state = mach_val();
    #1;
    eg = m_act ? N'(1 << m_cur) : '0;
    ed = (m_act && !m_ab && cyc == m_e) ? N'(1 << m_cur) : '0;
    chk($sformatf("c%0d start", cyc), 32'(mach_start), 32'(m_act && cyc == m_s));
    chk($sformatf("c%0d grant", cyc), 32'(grant), 32'(eg));
    chk($sformatf("c%0d done", cyc), 32'(done), 32'(ed));
    chk($sformatf("c%0d pending", cyc), 32'(pending), 32'(m_pend));
    chk($sformatf("c%0d busy", cyc), 32'(busy), 32'(m_act));
    chk($sformatf("c%0d terr", cyc), 32'(timeout_err), 32'(m_err));
    chk($sformatf("c%0d errid", cyc), 32'(err_id), 32'(m_eid));
    @(posedge clk);
    model_edge(r, clr, rs);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    cycle('0, 0, 1);
    cycle('0, 0, 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [3:0]   ms;
    logic         e_start;
    logic [N-1:0] e_grant;
    logic [N-1:0] e_done;
    logic [N-1:0] e_pend;
    logic         e_busy;
  } vec_t;

  vec_t tv[$];

  initial begin
    int nd, ns;
    logic [N-1:0] q_done[$];
    logic [N-1:0] q_start[$];
    bit redo;

    // single 8-cycle brew for source 2, then reset during WAIT_DONE for source 0
    tv.push_back('{1'b0, 4'b0100, 4'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    tv.push_back('{1'b0, 4'b0000, 4'd1, 1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b0});
    tv.push_back('{1'b0, 4'b0000, 4'd1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b1});
    for (int i = 0; i < 8; i++)
      tv.push_back('{1'b0, 4'b0000, 4'(3 + i), 1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1});
    tv.push_back('{1'b0, 4'b0000, 4'd1, 1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1});
    tv.push_back('{1'b0, 4'b0000, 4'd1, 1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1});
    tv.push_back('{1'b0, 4'b0000, 4'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    tv.push_back('{1'b0, 4'b0001, 4'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    tv.push_back('{1'b0, 4'b0000, 4'd1, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0});
    tv.push_back('{1'b0, 4'b0000, 4'd1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1});
    tv.push_back('{1'b0, 4'b0000, 4'd5, 1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1});
    tv.push_back('{1'b1, 4'b0000, 4'd5, 1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1});
    tv.push_back('{1'b0, 4'b0000, 4'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0});

    rst = 1'b1; req = '0; clr_err = 1'b0; mach_state = IC;
    repeat (2) @(posedge clk);
    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst; req = tv[i].req; mach_state = tv[i].ms;
      #1;
      chk($sformatf("tv%0d start", i), 32'(mach_start), 32'(tv[i].e_start));
      chk($sformatf("tv%0d grant", i), 32'(grant), 32'(tv[i].e_grant));
      chk($sformatf("tv%0d done", i), 32'(done), 32'(tv[i].e_done));
      chk($sformatf("tv%0d pending", i), 32'(pending), 32'(tv[i].e_pend));
      chk($sformatf("tv%0d busy", i), 32'(busy), 32'(tv[i].e_busy));
    end

    // ---------------- hand-written sequences ----------------
    cyc = 0; f_rand = 0; f_stuck = 0; f_a = 1; f_b = 8;
    model_reset();
    do_reset();

    // simultaneous 1011 -> served 0,1,3
    cycle(4'b1011, 0, 0);
    for (int i = 0; i < 60; i++) begin
      cycle('0, 0, 0);
      if (mach_start) q_start.push_back(grant);
      if (|done) q_done.push_back(done);
    end
    chk("multi ndone", q_done.size(), 3);
    chk("multi nstart", q_start.size(), 3);
    if (q_done.size() == 3) begin
      chk("multi d0", 32'(q_done[0]), 32'(4'b0001));
      chk("multi d1", 32'(q_done[1]), 32'(4'b0010));
      chk("multi d2", 32'(q_done[2]), 32'(4'b1000));
    end

    // req[1] held high with req[3] pending
    do_reset();
    f_b = 4;
    q_start.delete();
    for (int i = 0; i < 60; i++) begin
      cycle((i == 0) ? 4'b1010 : 4'b0010, 0, 0);
      if (mach_start) q_start.push_back(grant);
    end
    chk("starve nstart", 32'(q_start.size() >= 3), 1);
    if (q_start.size() >= 3) begin
      chk("starve g0", 32'(q_start[0]), 32'(4'b0010));
`ifdef SCHED_FIXED_PRIO_EN
      chk("starve g1", 32'(q_start[1]), 32'(4'b0010));
`else
      chk("starve g1", 32'(q_start[1]), 32'(4'b1000));
`endif
      chk("starve g2", 32'(q_start[2]), 32'(4'b0010));
    end

    // stuck machine -> abort, then clr_err
    do_reset();
    f_stuck = 1;
    nd = 0;
    cycle(4'b1000, 0, 0);
    for (int i = 0; i < 72; i++) begin
      cycle('0, 0, 0);
      if (|done) nd++;
    end
    chk("to ndone", nd, 0);
    chk("to terr", 32'(timeout_err), 1);
    chk("to errid", 32'(err_id), 3);
    chk("to pend", 32'(pending), 0);
    cycle('0, 1, 0);
    chk("clr terr", 32'(timeout_err), 0);
    chk("clr errid", 32'(err_id), 0);

    // watchdog boundary: last cycle that still completes, then one cycle later
    for (int t = 0; t < 2; t++) begin
      do_reset();
      f_stuck = 0; f_a = 1; f_b = 62 + t;
      nd = 0;
      cycle(4'b0010, 0, 0);
      for (int i = 0; i < 75; i++) begin
        cycle('0, 0, 0);
        if (|done) nd++;
      end
      chk($sformatf("bnd%0d ndone", t), nd, (t == 0) ? 1 : 0);
      chk($sformatf("bnd%0d terr", t), 32'(timeout_err), (t == 0) ? 0 : 1);
    end

    // req[0] re-asserted in its own DONE cycle
    do_reset();
    f_a = 1; f_b = 3;
    redo = 0; ns = 0;
    cycle(4'b0001, 0, 0);
    for (int i = 0; i < 30; i++) begin
      bit dn;
      dn = m_act && !m_ab && cyc == m_e && !redo;
      cycle(dn ? 4'b0001 : 4'b0000, 0, 0);
      if (dn) begin
        redo = 1;
        chk("redo pend", 32'(pending), 32'(4'b0001));
        chk("redo busy", 32'(busy), 0);
      end else if (redo && mach_start) begin
        ns++;
        chk("redo grant", 32'(grant), 32'(4'b0001));
      end
    end
    chk("redo restart", ns, 1);

    // reset during WAIT_DONE
    do_reset();
    f_b = 20;
    cycle(4'b0100, 0, 0);
    repeat (6) cycle('0, 0, 0);
    chk("mid busy", 32'(busy), 1);
    cycle('0, 0, 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst grant", 32'(grant), 0);
    chk("rst pend", 32'(pending), 0);
    chk("rst start", 32'(mach_start), 0);

    // ---------------- randomized traffic ----------------
    do_reset();
    f_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 7) == 0);
      cycle(r, $urandom_range(0, 15) == 0, $urandom_range(0, 399) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
